// File: rtl/lane_packer.sv
// Valid/ready symbol packer: gathers up to LANES symbols into a word, then hands the
// word and its {short, parity} tag to a registered output stage.
module lane_packer #(
   parameter int LANES = 3,
   parameter int SYM_W = 2,
   parameter int TAG_W = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [SYM_W-1:0]                in_sym,
   input  logic                            in_last,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [LANES-1:0][SYM_W-1:0]     out_word,
   output logic [TAG_W-1:0]                out_tag,
   output logic [$clog2(LANES+1)-1:0]      out_count
);
   localparam int CW = $clog2(LANES+1);

   logic [LANES-1:0][SYM_W-1:0] r_acc;
   logic [CW-1:0]               r_cnt;
   logic                        r_done;
   logic                        r_short;

   logic                        w_xfer;
   logic                        w_accept;
   logic [CW-1:0]               w_base_cnt;
   logic [LANES-1:0][SYM_W-1:0] w_nxt_acc;
   logic [CW-1:0]               w_nxt_cnt;
   logic                        w_nxt_done;
   logic                        w_nxt_short;

   assign w_xfer   = r_done && (!out_valid || out_ready);
   assign in_ready = !r_done || w_xfer;
   assign w_accept = in_valid && in_ready;

   // A transfer empties the assembly register first, so a symbol arriving in the
   // same cycle starts the next word in lane 0 without a bubble.
   always_comb begin
      w_base_cnt  = w_xfer ? '0 : r_cnt;
      w_nxt_acc   = w_xfer ? '0 : r_acc;
      w_nxt_cnt   = w_base_cnt;
      w_nxt_done  = w_xfer ? 1'b0 : r_done;
      w_nxt_short = r_short;
      if (w_accept) begin
         for (int i = 0; i < LANES; i++) begin
            if (w_base_cnt == CW'(i)) w_nxt_acc[i] = in_sym;
         end
         w_nxt_cnt = w_base_cnt + CW'(1);
         if (w_nxt_cnt == CW'(LANES) || in_last) begin
            w_nxt_done  = 1'b1;
            w_nxt_short = in_last && (w_nxt_cnt < CW'(LANES));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_short   <= 1'b0;
         out_valid <= 1'b0;
         out_word  <= '0;
         out_tag   <= '0;
         out_count <= '0;
      end else begin
         r_acc   <= w_nxt_acc;
         r_cnt   <= w_nxt_cnt;
         r_done  <= w_nxt_done;
         r_short <= w_nxt_short;
         if (w_xfer) begin
            out_word  <= r_acc;
            out_count <= r_cnt;
            out_tag   <= TAG_W'({r_short, ^r_acc});
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_lane_packer.sv
// Scoreboard bench for lane_packer: a queue-based word model fed from observed
// handshakes, with directed scenarios followed by randomized traffic.
module tb_lane_packer;
   localparam int LANES = 3;
   localparam int SYM_W = 2;
   localparam int TAG_W = 2;
   localparam int CW    = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_last = 1'b0;
   logic out_ready = 1'b0;
   logic [SYM_W-1:0] in_sym = '0;
   logic in_ready;
   logic out_valid;
   logic [LANES-1:0][SYM_W-1:0] out_word;
   logic [TAG_W-1:0] out_tag;
   logic [CW-1:0] out_count;

   lane_packer #(.LANES(LANES), .SYM_W(SYM_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sym(in_sym), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_word(out_word), .out_tag(out_tag),
      .out_count(out_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int stall_cnt = 0;
   int popped = 0;
   logic [9:0] exp_q[$];
   logic [SYM_W-1:0] part_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected {short, parity, count, word} for the symbols gathered so far.
   function automatic logic [9:0] model_word();
      logic [5:0] w;
      w = '0;
      for (int i = 0; i < part_q.size(); i++) w[i*SYM_W +: SYM_W] = part_q[i];
      return {part_q.size() < LANES, ^w, CW'(part_q.size()), w};
   endfunction

   initial begin
      logic pstall;
      logic [9:0] prev;
      pstall = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            part_q.delete();
            exp_q.delete();
            pstall = 1'b0;
         end else begin
            if (pstall) chk("hold", {out_tag, out_count, out_word}, prev);
            if (in_valid && in_ready) begin
               part_q.push_back(in_sym);
               if (part_q.size() == LANES || in_last) begin
                  exp_q.push_back(model_word());
                  part_q.delete();
               end
            end
            if (out_valid && out_ready) begin
               popped++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got %0h expected none", {out_tag, out_count, out_word});
               end else begin
                  chk("word", {out_tag, out_count, out_word}, exp_q.pop_front());
               end
            end
            pstall = out_valid && !out_ready;
            prev = {out_tag, out_count, out_word};
         end
      end
   end

   task automatic send(input logic [SYM_W-1:0] s, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_sym = s;
      in_last = l;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         stall_cnt++;
         n++;
         @(negedge clk);
      end
      if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!out_valid) chk("wait_out_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain", exp_q.size(), 0);
   endtask

   initial begin
      int p0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_word", 32'(out_word), 0);
      chk("rst_tag", 32'(out_tag), 0);
      chk("rst_count", 32'(out_count), 0);
      chk("rst_ready", 32'(in_ready), 1);
      @(posedge clk); #1;

      // full word plus latency
      out_ready = 1'b1;
      send(2'b01, 1'b0); send(2'b10, 1'b0); send(2'b11, 1'b0);
      idle();
      @(negedge clk);
      chk("lat_n1", 32'(out_valid), 0);
      @(negedge clk);
      chk("lat_n2", 32'(out_valid), 1);
      chk("t1_word", {out_tag, out_count, out_word}, {2'b00, 2'd3, 6'b111001});
      @(posedge clk); #1;

      // short words
      send(2'b01, 1'b0); send(2'b10, 1'b1);
      idle();
      wait_out();
      chk("t2_word", {out_tag, out_count, out_word}, {2'b10, 2'd2, 6'b001001});
      @(posedge clk); #1;
      send(2'b01, 1'b1);
      idle();
      wait_out();
      chk("t3_word", {out_tag, out_count, out_word}, {2'b11, 2'd1, 6'b000001});
      @(posedge clk); #1;

      // back-pressure
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(SYM_W'($urandom_range(3)), 1'b0);
      in_sym = 2'b01;
      repeat (3) begin
         @(negedge clk);
         chk("t4_blocked", 32'(in_ready), 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("t4_ready_same_cycle", 32'(in_ready), 1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      idle();
      @(negedge clk);
      chk("t4_word2_valid", 32'(out_valid), 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(2'b10, 1'b0); send(2'b11, 1'b0);
      idle();
      drain();

      // sustained rate
      stall_cnt = 0;
      p0 = popped;
      for (int i = 0; i < 12; i++) send(SYM_W'($urandom_range(3)), 1'b0);
      idle();
      chk("t5_no_stall", stall_cnt, 0);
      drain();
      chk("t5_words", popped - p0, 4);

      // mid-word reset
      send(2'b10, 1'b0); send(2'b01, 1'b0);
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_valid", 32'(out_valid), 0);
      chk("t6_word", 32'(out_word), 0);
      chk("t6_tag", 32'(out_tag), 0);
      chk("t6_count", 32'(out_count), 0);
      chk("t6_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      send(2'b11, 1'b0); send(2'b11, 1'b0); send(2'b11, 1'b0);
      idle();
      wait_out();
      chk("t6_fresh", {out_tag, out_count, out_word}, {2'b00, 2'd3, 6'b111111});
      drain();

      // random traffic
      for (int c = 0; c < 400; c++) begin
         in_valid = 1'($urandom_range(1));
         in_sym = SYM_W'($urandom_range(3));
         in_last = ($urandom_range(3) == 0);
         out_ready = ($urandom_range(3) != 0);
         @(posedge clk); #1;
      end
      idle();
      out_ready = 1'b1;
      send(2'b00, 1'b1);
      idle();
      drain();
      chk("partial_empty", part_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
